// File: rtl/mem_stage_pkg.sv
// Shared CPU profile constants and pipeline-boundary bus types used by the MEM stage.
package mem_stage_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned REG_IDX_W = 5;

    // Write-back data source selected by WB
    typedef enum logic [1:0] {
        WB_SEL_ALU = 2'd0,
        WB_SEL_MEM = 2'd1,
        WB_SEL_PC  = 2'd2
    } wb_sel_e;

    // Data-memory access state: nothing in flight / requesting / granted
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } mem_fsm_e;

    typedef struct packed {
        logic            mem_ren;
        logic            mem_wen;
        logic [XLEN-1:0] mem_wdata;
    } mem_ctrl_t;

    typedef struct packed {
        logic [REG_IDX_W-1:0] rd_idx;
        logic                 reg_wen;
        wb_sel_e              wb_wdata_sel;
        logic [XLEN-1:0]      alu_result;
        logic [XLEN-1:0]      pc_next;
        mem_ctrl_t            mem;
    } ex_mem_bus_t;

    typedef struct packed {
        logic [REG_IDX_W-1:0] rd_idx;
        logic                 reg_wen;
        wb_sel_e              wb_wdata_sel;
        logic [XLEN-1:0]      alu_result;
        logic [XLEN-1:0]      pc_next;
        logic [XLEN-1:0]      mem_rdata;
    } mem_wb_bus_t;

    // Top-level data-memory hookup
    typedef struct packed {
        logic            req;
        logic            we;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } dmem_req_t;

    typedef struct packed {
        logic            gnt;
        logic            rvalid;
        logic [XLEN-1:0] rdata;
    } dmem_rsp_t;

endpackage

// File: rtl/mem_stage.sv
// MEM pipeline stage: runs word loads/stores on a req/gnt/rvalid port,
// stalls upstream while an access is outstanding, registers the MEM/WB bus.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_mem_valid_i,
    input  ex_mem_bus_t       ex_mem_i,
    output logic              stall_o,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [XLEN-1:0]   dmem_addr_o,
    output logic [XLEN-1:0]   dmem_wdata_o,
    input  logic              dmem_gnt_i,
    input  logic              dmem_rvalid_i,
    input  logic [XLEN-1:0]   dmem_rdata_i,
    output logic              mem_wb_valid_o,
    output mem_wb_bus_t       mem_wb_o
);

    mem_fsm_e    r_state;
    mem_fsm_e    w_state_next;
    mem_wb_bus_t r_mem_wb;
    logic        r_mem_wb_valid;

    logic        w_is_mem;
    logic        w_is_store;
    logic        w_is_load;
    logic        w_complete;

    // Access FSM state register; reset drops any in-flight access
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Decode, completion, stall, memory request and next-state logic
    always_comb begin
        w_is_mem   = ex_mem_valid_i & (ex_mem_i.mem.mem_ren | ex_mem_i.mem.mem_wen);
        // write enable wins if both enables are (illegally) set
        w_is_store = w_is_mem & ex_mem_i.mem.mem_wen;
        w_is_load  = w_is_mem & ~ex_mem_i.mem.mem_wen;
        w_complete = ex_mem_valid_i & ~w_is_mem;
        w_state_next = r_state;

        unique case (r_state)
            IDLE: begin
                if (w_is_mem) begin
                    w_state_next = dmem_gnt_i ? WAIT : REQ;
                end
            end
            REQ: begin
                if (dmem_gnt_i) begin
                    w_state_next = WAIT;
                end
            end
            WAIT: begin
                // gnt is ignored here; only the response moves us on
                if (dmem_rvalid_i) begin
                    w_state_next = IDLE;
                    w_complete   = 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        stall_o      = w_is_mem & ~w_complete;
        dmem_req_o   = w_is_mem & (r_state != WAIT);
        dmem_we_o    = ex_mem_i.mem.mem_wen;
        dmem_addr_o  = ex_mem_i.alu_result;
        dmem_wdata_o = ex_mem_i.mem.mem_wdata;
    end

    // MEM/WB register: capture on completion, otherwise inject a bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_wb       <= '0;
            r_mem_wb_valid <= 1'b0;
        end else if (w_complete) begin
            r_mem_wb.rd_idx       <= ex_mem_i.rd_idx;
            r_mem_wb.reg_wen      <= ex_mem_i.reg_wen & ~w_is_store;
            r_mem_wb.wb_wdata_sel <= ex_mem_i.wb_wdata_sel;
            r_mem_wb.alu_result   <= ex_mem_i.alu_result;
            r_mem_wb.pc_next      <= ex_mem_i.pc_next;
            r_mem_wb.mem_rdata    <= w_is_load ? dmem_rdata_i : '0;
            r_mem_wb_valid        <= 1'b1;
        end else begin
            r_mem_wb.reg_wen      <= 1'b0;
            r_mem_wb_valid        <= 1'b0;
        end
    end

    assign mem_wb_o       = r_mem_wb;
    assign mem_wb_valid_o = r_mem_wb_valid;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: driver issues instructions and plays the
// memory side, monitor checks every MEM/WB output against queued expectations.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              ex_mem_valid_i;
    ex_mem_bus_t       ex_mem_i;
    logic              stall_o;
    logic              dmem_req_o;
    logic              dmem_we_o;
    logic [XLEN-1:0]   dmem_addr_o;
    logic [XLEN-1:0]   dmem_wdata_o;
    logic              dmem_gnt_i;
    logic              dmem_rvalid_i;
    logic [XLEN-1:0]   dmem_rdata_i;
    logic              mem_wb_valid_o;
    mem_wb_bus_t       mem_wb_o;

    typedef struct {
        mem_wb_bus_t payload;
        int          due;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    mem_stage dut (
        .clk            (clk),
        .rst            (rst),
        .ex_mem_valid_i (ex_mem_valid_i),
        .ex_mem_i       (ex_mem_i),
        .stall_o        (stall_o),
        .dmem_req_o     (dmem_req_o),
        .dmem_we_o      (dmem_we_o),
        .dmem_addr_o    (dmem_addr_o),
        .dmem_wdata_o   (dmem_wdata_o),
        .dmem_gnt_i     (dmem_gnt_i),
        .dmem_rvalid_i  (dmem_rvalid_i),
        .dmem_rdata_i   (dmem_rdata_i),
        .mem_wb_valid_o (mem_wb_valid_o),
        .mem_wb_o       (mem_wb_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // What WB should see for a completed instruction
    function automatic mem_wb_bus_t model(input ex_mem_bus_t ex, input logic [XLEN-1:0] rdata);
        mem_wb_bus_t m;
        m.rd_idx       = ex.rd_idx;
        m.wb_wdata_sel = ex.wb_wdata_sel;
        m.alu_result   = ex.alu_result;
        m.pc_next      = ex.pc_next;
        m.reg_wen      = ex.mem.mem_wen ? 1'b0 : ex.reg_wen;
        m.mem_rdata    = (ex.mem.mem_ren && !ex.mem.mem_wen) ? rdata : '0;
        return m;
    endfunction

    function automatic ex_mem_bus_t rand_ex();
        ex_mem_bus_t e;
        e.rd_idx        = 5'($urandom);
        e.reg_wen       = 1'($urandom);
        e.wb_wdata_sel  = wb_sel_e'($urandom_range(0, 2));
        e.alu_result    = $urandom;
        e.pc_next       = $urandom;
        e.mem.mem_wdata = $urandom;
        case ($urandom_range(0, 3))
            0:       begin e.mem.mem_ren = 1'b0; e.mem.mem_wen = 1'b0; end
            1:       begin e.mem.mem_ren = 1'b1; e.mem.mem_wen = 1'b0; end
            2:       begin e.mem.mem_ren = 1'b0; e.mem.mem_wen = 1'b1; end
            default: begin e.mem.mem_ren = 1'b1; e.mem.mem_wen = 1'b1; end
        endcase
        return e;
    endfunction

    // Present one instruction from posedge+1 until it completes.
    // gd = cycles without grant, rd = cycles from grant to response (>=1).
    // noise adds spurious rvalid before/at grant and spurious gnt after it.
    task automatic run_instr(input bit valid, input ex_mem_bus_t ex, input int gd, input int rd,
                             input logic [XLEN-1:0] rdata, input bit noise);
        bit   is_mem;
        int   nst;
        exp_t e;
        is_mem = valid && (ex.mem.mem_ren || ex.mem.mem_wen);
        nst    = is_mem ? gd + rd : 0;
        ex_mem_valid_i = valid;
        ex_mem_i       = ex;
        if (valid) begin
            e.payload = model(ex, rdata);
            e.due     = cyc + nst + 1;
            exp_q.push_back(e);
        end
        for (int k = 0; k <= nst; k++) begin
            if (is_mem) begin
                dmem_gnt_i    = (k == gd) || (noise && k > gd && $urandom_range(0, 1) == 1);
                dmem_rvalid_i = (k == nst) || (noise && k <= gd && $urandom_range(0, 1) == 1);
            end else begin
                dmem_gnt_i    = noise && $urandom_range(0, 1) == 1;
                dmem_rvalid_i = noise && $urandom_range(0, 1) == 1;
            end
            dmem_rdata_i = (is_mem && k == nst) ? rdata : $urandom;
            @(negedge clk);
            check("stall", 128'(stall_o), 128'(k < nst));
            check("dmem_req", 128'(dmem_req_o), 128'(is_mem && k <= gd));
            if (is_mem && k <= gd) begin
                check("dmem_we", 128'(dmem_we_o), 128'(ex.mem.mem_wen));
                check("dmem_addr", 128'(dmem_addr_o), 128'(ex.alu_result));
                check("dmem_wdata", 128'(dmem_wdata_o), 128'(ex.mem.mem_wdata));
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bubbles(input int n, input bit noise);
        for (int i = 0; i < n; i++) run_instr(1'b0, rand_ex(), 0, 1, '0, noise);
    endtask

    // Monitor: compare each WB output with the oldest expectation, on time
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (mem_wb_valid_o) begin
                    if (exp_q.size() == 0) begin
                        check("wb_unexpected_valid", 128'(mem_wb_valid_o), 128'(0));
                    end else begin
                        e = exp_q.pop_front();
                        check("wb_payload", 128'(mem_wb_o), 128'(e.payload));
                        check("wb_latency", 128'(cyc), 128'(e.due));
                    end
                end else begin
                    check("wb_bubble_reg_wen", 128'(mem_wb_o.reg_wen), 128'(0));
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        ex_mem_bus_t ex;
        rst            = 1'b1;
        ex_mem_valid_i = 1'b0;
        ex_mem_i       = '0;
        dmem_gnt_i     = 1'b0;
        dmem_rvalid_i  = 1'b1;
        dmem_rdata_i   = 32'hFFFF_FFFF;
        #12;
        check("rst_wb_valid", 128'(mem_wb_valid_o), 128'(0));
        check("rst_wb_payload", 128'(mem_wb_o), 128'(0));
        check("rst_stall", 128'(stall_o), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        dmem_rvalid_i = 1'b0;
        @(posedge clk);
        #1;

        // ALU op
        ex = '0;
        ex.reg_wen = 1'b1; ex.rd_idx = 5'd5; ex.alu_result = 32'h1234; ex.pc_next = 32'h0000_0044;
        run_instr(1'b1, ex, 0, 1, '0, 1'b0);

        // Load, immediate grant, response next cycle
        ex = '0;
        ex.mem.mem_ren = 1'b1; ex.reg_wen = 1'b1; ex.rd_idx = 5'd7;
        ex.wb_wdata_sel = WB_SEL_MEM; ex.alu_result = 32'h100; ex.pc_next = 32'h48;
        run_instr(1'b1, ex, 0, 1, 32'hDEAD_BEEF, 1'b0);

        // Store, grant after 2 cycles, response 3 cycles after grant
        ex = '0;
        ex.mem.mem_wen = 1'b1; ex.mem.mem_wdata = 32'hCAFE; ex.reg_wen = 1'b1; ex.rd_idx = 5'd9;
        ex.alu_result = 32'h200; ex.pc_next = 32'h4C;
        run_instr(1'b1, ex, 2, 3, 32'h5555_AAAA, 1'b0);
        bubbles(2, 1'b1);

        // Spurious rvalid in IDLE and REQ, spurious gnt in WAIT
        ex = rand_ex();
        ex.mem.mem_ren = 1'b1; ex.mem.mem_wen = 1'b0;
        run_instr(1'b1, ex, 3, 2, $urandom, 1'b1);

        // Back-to-back loads
        for (int i = 0; i < 2; i++) begin
            ex = rand_ex();
            ex.mem.mem_ren = 1'b1; ex.mem.mem_wen = 1'b0;
            run_instr(1'b1, ex, 0, 1, $urandom, 1'b0);
        end
        bubbles(2, 1'b0);

        // Reset while in WAIT, stale response afterwards
        ex = rand_ex();
        ex.mem.mem_ren = 1'b1; ex.mem.mem_wen = 1'b0;
        ex_mem_valid_i = 1'b1; ex_mem_i = ex; dmem_gnt_i = 1'b1; dmem_rvalid_i = 1'b0;
        @(negedge clk);
        check("rstw_req_idle", 128'(dmem_req_o), 128'(1));
        @(posedge clk);
        #1;
        dmem_gnt_i = 1'b0;
        @(negedge clk);
        check("rstw_req_wait", 128'(dmem_req_o), 128'(0));
        check("rstw_stall_wait", 128'(stall_o), 128'(1));
        #2;
        rst = 1'b1;
        #1;
        check("rstw_req_after_rst", 128'(dmem_req_o), 128'(1));
        check("rstw_wb_valid", 128'(mem_wb_valid_o), 128'(0));
        check("rstw_wb_payload", 128'(mem_wb_o), 128'(0));
        ex_mem_valid_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = $urandom;
        @(negedge clk);
        check("stale_stall", 128'(stall_o), 128'(0));
        check("stale_req", 128'(dmem_req_o), 128'(0));
        @(posedge clk);
        #1;
        dmem_rvalid_i = 1'b0;
        @(negedge clk);
        check("stale_wb_valid", 128'(mem_wb_valid_o), 128'(0));
        @(posedge clk);
        #1;
        // FSM must be back in IDLE: a delayed-grant load runs normally
        ex = rand_ex();
        ex.mem.mem_ren = 1'b1; ex.mem.mem_wen = 1'b0;
        run_instr(1'b1, ex, 1, 1, $urandom, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                bubbles(1, 1'b1);
            end else begin
                run_instr(1'b1, rand_ex(), int'($urandom_range(0, 3)), int'($urandom_range(1, 4)),
                          $urandom, 1'($urandom));
            end
        end
        bubbles(3, 1'b0);
        check("scoreboard_drained", 128'(exp_q.size()), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
